// File: rtl/fp_unpack_pipe.sv
// Two-stage multi-lane FP operand unpacker: half/single/double -> {sign, exp12, mant52} plus fclass.
// Stage 1 decodes fields and counts leading zeros; stage 2 normalises, classifies and holds the output.
module fp_unpack_pipe #(
  parameter int LANES   = 2,
  parameter bit NAN_BOX = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fp_unpack_i_flush,
  input  logic                  fp_unpack_i_valid,
  output logic                  fp_unpack_o_ready,
  input  logic [1:0]            fp_unpack_i_fmt,
  input  logic [64*LANES-1:0]   fp_unpack_i_data,
  output logic                  fp_unpack_o_valid,
  input  logic                  fp_unpack_i_ready,
  output logic [65*LANES-1:0]   fp_unpack_o_result,
  output logic [10*LANES-1:0]   fp_unpack_o_class,
  output logic                  fp_unpack_o_illegal
);

  localparam logic [1:0] FMT_S = 2'd0;
  localparam logic [1:0] FMT_D = 2'd1;
  localparam logic [1:0] FMT_H = 2'd2;
  localparam logic [1:0] FMT_X = 2'd3;

  logic s1_valid, s2_valid, s1_adv, s2_adv;
  logic [1:0] s1_fmt;

  logic [LANES-1:0]        s1_sign, s1_exp_zero, s1_exp_ones, s1_mant_zero, s1_box_bad;
  logic [LANES-1:0][10:0]  s1_exp;
  logic [LANES-1:0][51:0]  s1_mant;
  logic [LANES-1:0][5:0]   s1_z;

  logic [LANES-1:0]        nx_sign, nx_exp_ones, nx_box_bad;
  logic [LANES-1:0][10:0]  nx_exp;
  logic [LANES-1:0][51:0]  nx_mant;

  logic [65*LANES-1:0]     nx_result;
  logic [10*LANES-1:0]     nx_class;

  // Leading zeros of a left-aligned mantissa; the highest set bit wins.
  function automatic logic [5:0] lzc52(input logic [51:0] m);
    lzc52 = 6'd52;
    for (int i = 0; i < 52; i++)
      if (m[i]) lzc52 = 6'(51 - i);
  endfunction

  assign s2_adv            = ~s2_valid | fp_unpack_i_ready;
  assign s1_adv            = ~s1_valid | s2_adv;
  assign fp_unpack_o_ready = s1_adv;
  assign fp_unpack_o_valid = s2_valid;

  // Field decode; mantissas are left-aligned at bit 51 so one datapath serves all formats.
  always_comb begin
    nx_sign     = '0;
    nx_exp      = '0;
    nx_mant     = '0;
    nx_exp_ones = '0;
    nx_box_bad  = '0;
    for (int k = 0; k < LANES; k++) begin
      case (fp_unpack_i_fmt)
        FMT_H: begin
          nx_sign[k]     = fp_unpack_i_data[64*k+15];
          nx_exp[k]      = {6'b0, fp_unpack_i_data[64*k+10 +: 5]};
          nx_mant[k]     = {fp_unpack_i_data[64*k +: 10], 42'b0};
          nx_exp_ones[k] = &fp_unpack_i_data[64*k+10 +: 5];
          nx_box_bad[k]  = NAN_BOX && !(&fp_unpack_i_data[64*k+16 +: 48]);
        end
        FMT_S: begin
          nx_sign[k]     = fp_unpack_i_data[64*k+31];
          nx_exp[k]      = {3'b0, fp_unpack_i_data[64*k+23 +: 8]};
          nx_mant[k]     = {fp_unpack_i_data[64*k +: 23], 29'b0};
          nx_exp_ones[k] = &fp_unpack_i_data[64*k+23 +: 8];
          nx_box_bad[k]  = NAN_BOX && !(&fp_unpack_i_data[64*k+32 +: 32]);
        end
        default: begin
          nx_sign[k]     = fp_unpack_i_data[64*k+63];
          nx_exp[k]      = fp_unpack_i_data[64*k+52 +: 11];
          nx_mant[k]     = fp_unpack_i_data[64*k +: 52];
          nx_exp_ones[k] = &fp_unpack_i_data[64*k+52 +: 11];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                    s1_valid <= 1'b0;
    else if (fp_unpack_i_flush) s1_valid <= 1'b0;
    else if (s1_adv)            s1_valid <= fp_unpack_i_valid;
  end

  always_ff @(posedge clk) begin
    if (s1_adv && fp_unpack_i_valid) begin
      s1_fmt <= fp_unpack_i_fmt;
      for (int k = 0; k < LANES; k++) begin
        s1_sign[k]      <= nx_sign[k];
        s1_exp[k]       <= nx_exp[k];
        s1_mant[k]      <= nx_mant[k];
        s1_z[k]         <= lzc52(nx_mant[k]);
        s1_exp_zero[k]  <= (nx_exp[k] == 11'd0);
        s1_exp_ones[k]  <= nx_exp_ones[k];
        s1_mant_zero[k] <= (nx_mant[k] == 52'd0);
        s1_box_bad[k]   <= nx_box_bad[k];
      end
    end
  end

  // Stage 2: rebias, normalise subnormals, classify.
  always_comb begin
    logic [11:0] off, kexp, e12;
    logic [5:0]  sh;
    logic [51:0] m52;
    logic [9:0]  cls;
    nx_result = '0;
    nx_class  = '0;
    case (s1_fmt)
      FMT_H:   begin off = 12'h7F0; kexp = 12'h7F1; end
      FMT_S:   begin off = 12'h780; kexp = 12'h781; end
      default: begin off = 12'h400; kexp = 12'h401; end
    endcase
    for (int k = 0; k < LANES; k++) begin
      sh  = s1_z[k] + 6'd1;
      e12 = 12'd0;
      m52 = 52'd0;
      cls = 10'd0;
      if (s1_fmt == FMT_X) begin
        cls = 10'd0;
      end else if (s1_box_bad[k] && s1_fmt != FMT_D) begin
        e12    = 12'hFFF;
        m52    = {1'b1, 51'b0};
        cls[9] = 1'b1;
      end else if (s1_exp_ones[k]) begin
        e12 = 12'hFFF;
        m52 = s1_mant[k];
        if (s1_mant_zero[k])  cls[s1_sign[k] ? 0 : 7] = 1'b1;
        else if (m52[51])     cls[9] = 1'b1;
        else                  cls[8] = 1'b1;
      end else if (s1_exp_zero[k]) begin
        if (s1_mant_zero[k]) begin
          cls[s1_sign[k] ? 3 : 4] = 1'b1;
        end else begin
          e12 = kexp - {6'b0, sh};
          m52 = s1_mant[k] << sh;
          cls[s1_sign[k] ? 2 : 5] = 1'b1;
        end
      end else begin
        e12 = {1'b0, s1_exp[k]} + off;
        m52 = s1_mant[k];
        cls[s1_sign[k] ? 1 : 6] = 1'b1;
      end
      if (s1_fmt != FMT_X)
        nx_result[65*k +: 65] = {(s1_box_bad[k] && s1_fmt != FMT_D) ? 1'b0 : s1_sign[k], e12, m52};
      nx_class[10*k +: 10] = cls;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid            <= 1'b0;
      fp_unpack_o_result  <= '0;
      fp_unpack_o_class   <= '0;
      fp_unpack_o_illegal <= 1'b0;
    end else begin
      if (fp_unpack_i_flush) s2_valid <= 1'b0;
      else if (s2_adv)       s2_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        fp_unpack_o_result  <= nx_result;
        fp_unpack_o_class   <= nx_class;
        fp_unpack_o_illegal <= (s1_fmt == FMT_X);
      end
    end
  end

endmodule

// File: tb/tb_fp_unpack_pipe.sv
// Scoreboard bench for fp_unpack_pipe: directed spec vectors, back-pressure, flush, reset,
// then randomized traffic checked against a value-level reference model.
module tb_fp_unpack_pipe;
  localparam int LANES = 2;

  logic                 clk = 1'b0;
  logic                 rst, flush, i_valid, o_ready, o_valid, i_ready, o_illegal;
  logic [1:0]           fmt;
  logic [64*LANES-1:0]  data;
  logic [65*LANES-1:0]  o_result;
  logic [10*LANES-1:0]  o_class;

  typedef struct packed {
    logic [65*LANES-1:0] res;
    logic [10*LANES-1:0] cls;
    logic                ill;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_unpack_pipe #(.LANES(LANES), .NAN_BOX(1'b1)) dut (
    .clk(clk), .rst(rst),
    .fp_unpack_i_flush(flush), .fp_unpack_i_valid(i_valid), .fp_unpack_o_ready(o_ready),
    .fp_unpack_i_fmt(fmt), .fp_unpack_i_data(data),
    .fp_unpack_o_valid(o_valid), .fp_unpack_i_ready(i_ready),
    .fp_unpack_o_result(o_result), .fp_unpack_o_class(o_class), .fp_unpack_o_illegal(o_illegal)
  );

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  // Reference: decode the value and re-encode it with bias 2047, working from the numeric meaning.
  function automatic logic [74:0] ref_lane(input logic [63:0] d, input logic [1:0] f);
    int E, M, bias, p, ev;
    logic [63:0] e, m, frac, mask_m;
    logic s;
    logic [64:0] res;
    logic [9:0] cls;
    if (f == 2'd3) return '0;
    case (f)
      2'd2:    begin E = 5;  M = 10; bias = 15;   end
      2'd0:    begin E = 8;  M = 23; bias = 127;  end
      default: begin E = 11; M = 52; bias = 1023; end
    endcase
    if ((f == 2'd2 && d[63:16] != '1) || (f == 2'd0 && d[63:32] != '1))
      return {65'h0_FFF8_0000_0000_0000, 10'h200};
    mask_m = (64'd1 << M) - 1;
    s = d[E+M];
    e = (d >> M) & ((64'd1 << E) - 1);
    m = d & mask_m;
    cls = '0;
    if (e == (64'd1 << E) - 1) begin
      res = {s, 12'hFFF, 52'(m << (52 - M))};
      if (m == 0) cls[s ? 0 : 7] = 1'b1;
      else cls[m[M-1] ? 9 : 8] = 1'b1;
    end else if (e == 0) begin
      if (m == 0) begin
        res = {s, 64'd0};
        cls[s ? 3 : 4] = 1'b1;
      end else begin
        p = 0;
        for (int i = 0; i < M; i++) if (m[i]) p = i;
        ev = p + 1 - bias - M + 2047;
        frac = (m << (M - p)) & mask_m;
        res = {s, 12'(ev), 52'(frac << (52 - M))};
        cls[s ? 2 : 5] = 1'b1;
      end
    end else begin
      ev = int'(e) - bias + 2047;
      res = {s, 12'(ev), 52'(m << (52 - M))};
      cls[s ? 1 : 6] = 1'b1;
    end
    return {res, cls};
  endfunction

  function automatic exp_t model(input logic [64*LANES-1:0] d, input logic [1:0] f);
    exp_t r;
    logic [74:0] l;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      l = ref_lane(d[64*k +: 64], f);
      r.res[65*k +: 65] = l[74:10];
      r.cls[10*k +: 10] = l[9:0];
    end
    r.ill = (f == 2'd3);
    return r;
  endfunction

  function automatic logic [63:0] gen_lane(input logic [1:0] f);
    int E, M;
    logic [63:0] d, e, m;
    d = {$urandom, $urandom};
    if (f == 2'd3) return d;
    case (f)
      2'd2:    begin E = 5;  M = 10; end
      2'd0:    begin E = 8;  M = 23; end
      default: begin E = 11; M = 52; end
    endcase
    case ($urandom % 4)
      0:       e = 0;
      1:       e = '1;
      default: e = {$urandom, $urandom};
    endcase
    e &= (64'd1 << E) - 1;
    m = {$urandom, $urandom} & ((64'd1 << M) - 1);
    if ($urandom % 4 == 0) m = m >> ($urandom % M);
    if ($urandom % 5 == 0) m = 0;
    d = (64'($urandom % 2) << (E + M)) | (e << M) | m;
    if (f != 2'd1) begin
      if ($urandom % 8 == 0) d |= {$urandom, $urandom} & ~((64'd1 << (E + M + 1)) - 1);
      else d |= ~((64'd1 << (E + M + 1)) - 1);
    end
    return d;
  endfunction

  // Inputs change just after posedge; acceptance is judged at the following negedge.
  task automatic drive(input logic v, input logic [1:0] f, input logic [64*LANES-1:0] d,
                       input logic rdy, input logic fl, input logic use_e, input exp_t e,
                       output logic acc);
    i_valid = v; fmt = f; data = d; i_ready = rdy; flush = fl;
    @(negedge clk);
    acc = v & o_ready & ~fl;
    if (acc) q.push_back(use_e ? e : model(d, f));
    @(posedge clk); #1;
    if (fl) q.delete();
  endtask

  task automatic send(input logic [1:0] f, input logic [64*LANES-1:0] d, input logic rdy,
                      input logic use_e, input exp_t e);
    logic acc;
    int n;
    n = 0;
    do begin
      drive(1'b1, f, d, rdy, 1'b0, use_e, e, acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) check("send_timeout", 0, 1);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    i_valid = 1'b0; i_ready = 1'b1; flush = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  function automatic exp_t mk(input logic [64:0] r, input logic [9:0] c, input logic ill);
    exp_t x;
    x.res = {LANES{r}};
    x.cls = {LANES{c}};
    x.ill = ill;
    return x;
  endfunction

  // Monitor: every presented output is checked against the queue head; popped on transfer.
  initial begin
    exp_t h;
    forever begin
      @(negedge clk);
      if (!rst && o_valid) begin
        if (q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          h = q[0];
          check("out_result", o_result, h.res);
          check("out_class", o_class, h.cls);
          check("out_illegal", o_illegal, h.ill);
          if (i_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic acc;
    logic [1:0] f;
    logic [64*LANES-1:0] d;
    rst = 1'b1; flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1; fmt = 2'd0; data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_o_valid", o_valid, 0);
    check("reset_o_ready", o_ready, 1);
    check("reset_result", o_result, 0);
    check("reset_class", o_class, 0);
    check("reset_illegal", o_illegal, 0);
    @(posedge clk); #1;

    send(2'd0, {LANES{64'hFFFFFFFF_3F800000}}, 1'b1, 1'b1, mk(65'h0_7FF0_0000_0000_0000, 10'h040, 1'b0));
    send(2'd0, {LANES{64'hFFFFFFFF_00000001}}, 1'b1, 1'b1, mk(65'h0_76A0_0000_0000_0000, 10'h020, 1'b0));
    send(2'd1, {LANES{64'h7FF0_0000_0000_0001}}, 1'b1, 1'b1, mk(65'h0_FFF0_0000_0000_0001, 10'h100, 1'b0));
    send(2'd2, {LANES{64'hFFFFFFFF_FFFFFC00}}, 1'b1, 1'b1, mk(65'h1_FFF0_0000_0000_0000, 10'h001, 1'b0));
    send(2'd0, {LANES{64'h00000000_3F800000}}, 1'b1, 1'b1, mk(65'h0_FFF8_0000_0000_0000, 10'h200, 1'b0));
    send(2'd3, {LANES{64'h0123_4567_89AB_CDEF}}, 1'b1, 1'b1, mk(65'h0, 10'h000, 1'b1));
    drain();

    // Back-pressure: two items fill the pipe, the third must wait while A is held.
    send(2'd1, {64'h3FF0_0000_0000_0000, 64'hC000_0000_0000_0000}, 1'b0, 1'b0, '0);
    send(2'd2, {64'hFFFF_FFFF_FFFF_0001, 64'hFFFF_FFFF_FFFF_8000}, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd0, {LANES{64'hFFFFFFFF_007FFFFF}}, 1'b0, 1'b0, 1'b0, '0, acc);
      check("bp_o_ready_low", acc, 0);
    end
    send(2'd0, {LANES{64'hFFFFFFFF_007FFFFF}}, 1'b1, 1'b0, '0);
    drain();

    // Flush with two items in flight and a valid input in the same cycle.
    send(2'd0, {LANES{64'hFFFFFFFF_40490FDB}}, 1'b0, 1'b0, '0);
    send(2'd0, {LANES{64'hFFFFFFFF_C0000000}}, 1'b0, 1'b0, '0);
    drive(1'b1, 2'd1, {LANES{64'h1}}, 1'b0, 1'b1, 1'b0, '0, acc);
    check("flush_input_dropped", acc, 0);
    i_valid = 1'b0; flush = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    check("flush_o_valid", o_valid, 0);
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    drain();

    // Reset mid-stream.
    send(2'd1, {LANES{64'h8000_0000_0000_0003}}, 1'b0, 1'b0, '0);
    send(2'd1, {LANES{64'h0010_0000_0000_0000}}, 1'b0, 1'b0, '0);
    rst = 1'b1; i_valid = 1'b1; i_ready = 1'b0;
    @(posedge clk); #1;
    q.delete();
    rst = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_o_valid", o_valid, 0);
    check("rst_mid_o_ready", o_ready, 1);
    @(posedge clk); #1;

    // Randomized traffic with random stalls and occasional flushes.
    for (int c = 0; c < 1500; c++) begin
      logic v, rdy, fl;
      f = ($urandom % 8 == 7) ? 2'd3 : 2'($urandom % 3);
      for (int k = 0; k < LANES; k++) d[64*k +: 64] = gen_lane(f);
      v   = ($urandom % 4) != 0;
      rdy = ($urandom % 4) != 0;
      fl  = ($urandom % 60) == 0;
      if (fl) rdy = 1'b0;
      drive(v, f, d, rdy, fl, 1'b0, '0, acc);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
